// File: rtl/uart_alu_interface_if.sv
// Bundled RX/ALU/TX signals of uart_alu_interface; original port names kept as members.
// master: the uart_alu_interface block, slave: the surrounding RX/TX/ALU environment.
interface uart_alu_interface_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic               i_frame_valid;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_opcode;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_err;

    modport master (
        input  i_rx_data, i_rx_done, i_frame_valid, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_err
    );

    modport slave (
        output i_rx_data, i_rx_done, i_frame_valid, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_err
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, drives the ALU, hands the result to the TX.
// Optional UART_ALU_IF_PARITY_DROP_EN: discard bytes whose i_frame_valid is low and pulse o_err.
module uart_alu_interface #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    uart_alu_interface_if.master   bus
);

    typedef enum logic [2:0] {
        ST_WAIT_A,
        ST_WAIT_B,
        ST_WAIT_OP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic               rx_done_d;
    logic               rx_evt;
    logic               rx_accept;
    logic               rx_drop;
    logic               receiving;
    logic               watching;
    logic               tmo_hit;
    logic [NB_TIMEOUT-1:0] tmo_cnt;

    logic               ld_a;
    logic               ld_b;
    logic               ld_op;
    logic               ld_tx;
    logic               err_next;

    logic [NB_DATA-1:0] data_a;
    logic [NB_DATA-1:0] data_b;
    logic [NB_OP-1:0]   opcode;
    logic [NB_DATA-1:0] tx_data;
    logic               tx_start;
    logic               err;

    // Rising edge of the receiver's level flag: one event per byte.
    assign rx_evt    = bus.i_rx_done & ~rx_done_d;
    assign receiving = (state == ST_WAIT_A) || (state == ST_WAIT_B) || (state == ST_WAIT_OP);
    assign watching  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);

`ifdef UART_ALU_IF_PARITY_DROP_EN
    assign rx_accept = rx_evt & bus.i_frame_valid;
    assign rx_drop   = rx_evt & ~bus.i_frame_valid & receiving;
`else
    assign rx_accept = rx_evt;
    assign rx_drop   = 1'b0;
`endif

    // An accepted byte in the same cycle beats the watchdog.
    assign tmo_hit = watching && (tmo_cnt == TMO_LAST) && !rx_accept;

    always_comb begin
        state_next = state;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        ld_op      = 1'b0;
        ld_tx      = 1'b0;
        err_next   = tmo_hit | rx_drop;
        case (state)
            ST_WAIT_A: begin
                if (rx_accept) begin
                    ld_a       = 1'b1;
                    state_next = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (rx_accept) begin
                    ld_b       = 1'b1;
                    state_next = ST_WAIT_OP;
                end else if (tmo_hit) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_WAIT_OP: begin
                if (rx_accept) begin
                    ld_op      = 1'b1;
                    state_next = ST_SEND;
                end else if (tmo_hit) begin
                    state_next = ST_WAIT_A;
                end
            end
            ST_SEND: begin
                ld_tx      = 1'b1;
                state_next = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (bus.i_tx_done) begin
                    state_next = ST_WAIT_A;
                end
            end
            default: state_next = ST_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state     <= ST_WAIT_A;
            rx_done_d <= 1'b0;
            tmo_cnt   <= '0;
            data_a    <= '0;
            data_b    <= '0;
            opcode    <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            rx_done_d <= bus.i_rx_done;
            tx_start  <= ld_tx;
            err       <= err_next;
            if (ld_a)  data_a  <= bus.i_rx_data;
            if (ld_b)  data_b  <= bus.i_rx_data;
            if (ld_op) opcode  <= bus.i_rx_data[NB_OP-1:0];
            if (ld_tx) tx_data <= bus.i_alu_result;
            // Outside B/OP the count is held at zero, which covers the clear on entry to WAIT_A.
            if (rx_accept || tmo_hit || !watching) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    assign bus.o_data_a   = data_a;
    assign bus.o_data_b   = data_b;
    assign bus.o_opcode   = opcode;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_start = tx_start;
    assign bus.o_err      = err;
    assign bus.o_busy     = (state == ST_SEND) || (state == ST_WAIT_TX);

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sits directly downstream of the UART receiver, between the RX/TX pair and the ALU.
- Assembles three consecutive received bytes into the ALU operands: operand A, then operand B, then the opcode.
- Holds those operands stable for the combinational ALU, then hands the ALU result to the UART transmitter with a start/done handshake.
- A watchdog abandons a partially received command if the link goes quiet.

Parameters:
- NB_DATA, 8, width of received byte, operands and ALU result.
- NB_OP, 6, opcode width; taken from the low NB_OP bits of the third byte.
- TIMEOUT_CYCLES, 1000000, i_clock cycles allowed between bytes while in ST_WAIT_B or ST_WAIT_OP.
- NB_TIMEOUT, 20, timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT_CYCLES.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_DATA  received byte from the UART receiver.
- i_rx_done  in  1  receiver data-ready level; may stay high for many clocks per byte.
- i_frame_valid  in  1  receiver parity-check result.
- i_alu_result  in  NB_DATA  combinational ALU output.
- i_tx_done  in  1  transmitter frame-complete pulse.
- o_data_a  out  NB_DATA  operand A to the ALU.
- o_data_b  out  NB_DATA  operand B to the ALU.
- o_opcode  out  NB_OP  opcode to the ALU.
- o_tx_data  out  NB_DATA  byte to transmit.
- o_tx_start  out  1  one-cycle transmit request.
- o_busy  out  1  high in ST_SEND and ST_WAIT_TX.
- o_err  out  1  one-cycle pulse on timeout or a dropped frame.

Behaviour:
- Reset: all outputs 0; state ST_WAIT_A; timeout counter 0; rx_done delay register 0.
- Byte event: rx_evt = i_rx_done & ~rx_done_d, where rx_done_d is i_rx_done registered every clock.
  - Exactly one event per byte, however long i_rx_done is held.
- FSM (registered state, updates every clock):
  - ST_WAIT_A: on rx_evt, o_data_a <= i_rx_data, go to ST_WAIT_B.
  - ST_WAIT_B: on rx_evt, o_data_b <= i_rx_data, go to ST_WAIT_OP.
  - ST_WAIT_OP: on rx_evt, o_opcode <= i_rx_data[NB_OP-1:0], go to ST_SEND.
  - ST_SEND: o_tx_data <= i_alu_result, o_tx_start <= 1 for exactly one cycle, go to ST_WAIT_TX.
    - The ALU result is sampled one cycle after the opcode register updates, which gives the ALU one full clock to settle.
  - ST_WAIT_TX: on i_tx_done, go to ST_WAIT_A.
    - rx_evt in this state (or in ST_SEND) is ignored; the byte is lost and no o_err is raised.
- Operand registers hold their values until overwritten; they are not cleared between commands.
- Watchdog:
  - Counter clears on every rx_evt and on entry to ST_WAIT_A.
  - Counts only in ST_WAIT_B and ST_WAIT_OP.
  - When the count reaches TIMEOUT_CYCLES-1 with no rx_evt that cycle: go to ST_WAIT_A, pulse o_err, clear the counter.
  - Operands already written are kept.
- Simultaneous events:
  - rx_evt and timeout in the same cycle: rx_evt wins (byte accepted, counter cleared).
  - i_tx_done outside ST_WAIT_TX is ignored.
- Reset mid-operation: returns to ST_WAIT_A next cycle; o_tx_start is forced 0 even if ST_SEND was in progress.
- o_busy is combinational from state.
- o_tx_start and o_err are registered.

Optional Feature:
- Macro: UART_ALU_IF_PARITY_DROP_EN.
- Defined: an rx_evt with i_frame_valid=0 is discarded.
  - State unchanged, no register written.
  - o_err pulses for one cycle.
  - Watchdog counter is not cleared.
- Undefined: i_frame_valid is ignored and every rx_evt is accepted.

Test Plan:
- Bytes 0x05, 0x03, 0x20 (ADD), ALU model returns 0x08:
  - o_data_a=0x05, o_data_b=0x03, o_opcode=0x20.
  - o_tx_start pulses once with o_tx_data=0x08 one cycle after o_opcode updates.
  - After i_tx_done: state ST_WAIT_A, o_busy=0.
- i_rx_done held high 16 clocks per byte for 0xAA, 0x55, 0x24:
  - Exactly three captures: A=0xAA, B=0x55, OP=0x24.
  - No duplicate captures.
- TIMEOUT_CYCLES=50; send 0x11, then idle 60 cycles, then send 0x22:
  - o_err pulses once at cycle 50.
  - 0x22 lands in o_data_a, and o_data_a=0x22.
- Send a fourth byte 0x77 while in ST_WAIT_TX:
  - No operand change and no o_err.
  - After i_tx_done, the next byte goes to o_data_a.
- Assert i_reset in ST_WAIT_OP with A=0x12, B=0x34:
  - All outputs 0 and state ST_WAIT_A next cycle.
  - A new 3-byte command completes normally.
- With the macro defined, the B byte arrives with i_frame_valid=0:
  - o_err pulses; o_data_b unchanged; state stays ST_WAIT_B.
  - A retransmitted B with i_frame_valid=1 is accepted.
